// File: rtl/rgb_led_sequencer_pkg.sv
// Shared types and constants for the RGB LED sequencer: FSM states,
// the eight 3-bit colours and the channel bit positions within the LED drive.
package rgb_seq_pkg;

  typedef enum logic [1:0] {
    S_OFF    = 2'd0,
    S_AUTO   = 2'd1,
    S_MANUAL = 2'd2
  } seq_state_t;

  localparam logic [2:0] BLACK   = 3'd0;
  localparam logic [2:0] RED     = 3'd1;
  localparam logic [2:0] GREEN   = 3'd2;
  localparam logic [2:0] YELLOW  = 3'd3;
  localparam logic [2:0] BLUE    = 3'd4;
  localparam logic [2:0] MAGENTA = 3'd5;
  localparam logic [2:0] CYAN    = 3'd6;
  localparam logic [2:0] WHITE   = 3'd7;

  localparam int unsigned CH_R     = 0;
  localparam int unsigned CH_G     = 1;
  localparam int unsigned CH_B     = 2;
  localparam int unsigned LED1_OFS = 3;

endpackage

// File: rtl/rgb_led_sequencer_if.sv
// Control/drive bundle of the RGB LED sequencer: switch mask, mode, step,
// brightness in; LED drive and colour index out.
interface rgb_led_sequencer_if;

  logic [5:0] sw;
  logic       auto_en;
  logic       step;
  logic [7:0] bright;
  logic [5:0] out;
  logic [2:0] color_idx;

  modport master (output sw, auto_en, step, bright, input out, color_idx);
  modport slave  (input sw, auto_en, step, bright, output out, color_idx);

endinterface

// File: rtl/rgb_led_sequencer_timebase.sv
// PWM timebase: prescaler producing tick, 8-bit PWM counter, and wrap on the
// tick that rolls the counter over from 255.
module rgb_pwm_timebase #(
  parameter int unsigned PRESCALE = 4
) (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] o_pwm_cnt,
  output logic       o_tick,
  output logic       o_wrap
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] r_presc;
  logic [7:0]    r_pwm_cnt;

  assign o_tick    = (r_presc == P_LAST);
  assign o_wrap    = o_tick && (r_pwm_cnt == 8'hFF);
  assign o_pwm_cnt = r_pwm_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc   <= '0;
      r_pwm_cnt <= '0;
    end else begin
      r_presc <= o_tick ? '0 : r_presc + 1'b1;
      if (o_tick) r_pwm_cnt <= r_pwm_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/rgb_led_sequencer.sv
// RGB LED sequencer top: colour FSM (off/auto/manual), auto hold counter and
// registered PWM LED drive. Define RGB_SEQ_COMPLEMENT_EN for LED1 = ~LED0 colour.
module rgb_led_sequencer
  import rgb_seq_pkg::*;
#(
  parameter int unsigned PRESCALE     = 4,
  parameter int unsigned HOLD_PERIODS = 256
) (
  input logic               clk,
  input logic               rst,
  rgb_led_sequencer_if.slave bus
);

  localparam int unsigned HW = (HOLD_PERIODS > 1) ? $clog2(HOLD_PERIODS) : 1;
  localparam logic [HW-1:0] H_LAST = HW'(HOLD_PERIODS - 1);

  logic [7:0]    w_pwm_cnt;
  logic          w_tick;
  logic          w_wrap;
  logic          w_pwm_on;
  logic [2:0]    w_led1;
  logic [5:0]    w_colors;
  logic [5:0]    w_out_nxt;

  seq_state_t    r_state;
  seq_state_t    w_state_nxt;
  logic [2:0]    r_color_idx;
  logic [2:0]    w_color_nxt;
  logic [HW-1:0] r_hold_cnt;
  logic [HW-1:0] w_hold_nxt;
  logic [5:0]    r_out;

  rgb_pwm_timebase #(.PRESCALE(PRESCALE)) u_timebase (
    .clk       (clk),
    .rst       (rst),
    .o_pwm_cnt (w_pwm_cnt),
    .o_tick    (w_tick),
    .o_wrap    (w_wrap)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_OFF;
      r_color_idx <= BLACK;
      r_hold_cnt  <= '0;
      r_out       <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_color_idx <= w_color_nxt;
      r_hold_cnt  <= w_hold_nxt;
      r_out       <= w_out_nxt;
    end
  end

  // Mode changes take priority: a step or wrap coinciding with one is dropped.
  always_comb begin
    w_state_nxt = r_state;
    w_color_nxt = r_color_idx;
    w_hold_nxt  = r_hold_cnt;
    unique case (r_state)
      S_OFF, S_MANUAL: begin
        if (bus.auto_en) begin
          w_state_nxt = S_AUTO;
          w_hold_nxt  = '0;
        end else if (bus.step) begin
          w_state_nxt = S_MANUAL;
          w_color_nxt = r_color_idx + 3'd1;
        end
      end
      S_AUTO: begin
        if (!bus.auto_en) begin
          w_state_nxt = S_MANUAL;
        end else if (w_tick && w_wrap) begin
          if (r_hold_cnt == H_LAST) begin
            w_hold_nxt  = '0;
            w_color_nxt = r_color_idx + 3'd1;
          end else begin
            w_hold_nxt = r_hold_cnt + 1'b1;
          end
        end
      end
      default: w_state_nxt = S_OFF;
    endcase
  end

`ifdef RGB_SEQ_COMPLEMENT_EN
  assign w_led1 = ~r_color_idx;
`else
  assign w_led1 = r_color_idx;
`endif

  assign w_pwm_on = (w_pwm_cnt < bus.bright);

  always_comb begin
    w_colors                  = '0;
    w_colors[CH_R]            = r_color_idx[CH_R];
    w_colors[CH_G]            = r_color_idx[CH_G];
    w_colors[CH_B]            = r_color_idx[CH_B];
    w_colors[LED1_OFS + CH_R] = w_led1[CH_R];
    w_colors[LED1_OFS + CH_G] = w_led1[CH_G];
    w_colors[LED1_OFS + CH_B] = w_led1[CH_B];
    w_out_nxt = '0;
    if ((r_state != S_OFF) && w_pwm_on) w_out_nxt = w_colors & bus.sw;
  end

  assign bus.out       = r_out;
  assign bus.color_idx = r_color_idx;

endmodule

// File: tb/tb_rgb_led_sequencer.sv
// Self-checking bench for rgb_led_sequencer (PRESCALE=1, HOLD_PERIODS=2) with
// randomized stimulus against a time-based behavioural model.
module tb_rgb_led_sequencer;

  localparam int unsigned PRESCALE = 1;
  localparam int unsigned HOLD     = 2;
`ifdef RGB_SEQ_COMPLEMENT_EN
  localparam bit COMP = 1'b1;
`else
  localparam bit COMP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  rgb_led_sequencer_if bus ();

  rgb_led_sequencer #(.PRESCALE(PRESCALE), .HOLD_PERIODS(HOLD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  // Model: mode 0=off 1=auto 2=manual; time since reset gives the PWM phase.
  int unsigned m_t     = 0;
  int          m_mode  = 0;
  logic [2:0]  m_idx   = 3'd0;
  int unsigned m_wraps = 0;
  logic [5:0]  m_out   = 6'h00;

  task automatic model_step();
    int unsigned pwm;
    bit          wrap;
    logic [2:0]  c1;
    logic [5:0]  col;
    if (rst) begin
      m_t = 0; m_mode = 0; m_idx = 3'd0; m_wraps = 0; m_out = 6'h00;
      return;
    end
    pwm  = (m_t / PRESCALE) % 256;
    wrap = ((m_t % PRESCALE) == PRESCALE - 1) && (pwm == 255);
    c1   = COMP ? ~m_idx : m_idx;
    col  = {c1, m_idx};
    m_out = (m_mode == 0 || pwm >= {24'd0, bus.bright}) ? 6'h00 : (col & bus.sw);
    case (m_mode)
      0, 2: begin
        if (bus.auto_en) begin m_mode = 1; m_wraps = 0; end
        else if (bus.step) begin m_mode = 2; m_idx = m_idx + 3'd1; end
      end
      default: begin
        if (!bus.auto_en) m_mode = 2;
        else if (wrap) begin
          m_wraps++;
          if (m_wraps % HOLD == 0) m_idx = m_idx + 3'd1;
        end
      end
    endcase
    m_t++;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.auto_en = 1'b0; bus.step = 1'b0;
    bus.sw = 6'($urandom); bus.bright = 8'($urandom);
    repeat (3) cyc();
    n_total++;
    if (bus.out !== 6'h00 || bus.color_idx !== 3'd0)
      $display("FAIL reset_values: out=%h idx=%0d, expected out=00 idx=0", bus.out, bus.color_idx);
    else n_pass++;
    rst = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      bus.sw = 6'($urandom); bus.bright = 8'($urandom);
      cyc();
      n_total++;
      if (bus.out !== 6'h00 || bus.color_idx !== 3'd0)
        $display("FAIL reset_idle c%0d: out=%h idx=%0d, expected out=00 idx=0", i, bus.out, bus.color_idx);
      else n_pass++;
    end
  endtask

  task automatic test_manual_step();
    int unsigned cnt [6];
    logic [5:0]  mask;
    bus.sw = 6'h3F; bus.bright = 8'd255;
    for (int k = 0; k < 3; k++) begin
      bus.step = 1'b1; cyc(); bus.step = 1'b0;
      repeat ($urandom_range(1, 5)) cyc();
    end
    n_total++;
    if (bus.color_idx !== 3'd3)
      $display("FAIL step_x3_idx: idx=%0d, expected 3", bus.color_idx);
    else n_pass++;
    for (int i = 0; i < 6; i++) cnt[i] = 0;
    for (int c = 0; c < 256; c++) begin
      cyc();
      for (int i = 0; i < 6; i++) cnt[i] += 32'(bus.out[i]);
      n_total++;
      if (bus.out !== m_out || bus.color_idx !== m_idx)
        $display("FAIL manual_model c%0d: out=%h idx=%0d, expected out=%h idx=%0d", c, bus.out, bus.color_idx, m_out, m_idx);
      else n_pass++;
    end
    mask = COMP ? 6'b100_011 : 6'b011_011;
    for (int i = 0; i < 6; i++) begin
      n_total++;
      if (cnt[i] !== (mask[i] ? 32'd255 : 32'd0))
        $display("FAIL yellow_duty bit%0d: high %0d cycles, expected %0d", i, cnt[i], mask[i] ? 255 : 0);
      else n_pass++;
    end
  endtask

  task automatic test_auto();
    logic [2:0]  prev;
    int unsigned last_chg;
    int unsigned changes = 0;
    bit          seen_wrap = 1'b0;
    bus.auto_en = 1'b1;
    prev = bus.color_idx;
    for (int unsigned c = 0; c < 5000; c++) begin
      bus.step = ($urandom_range(0, 15) == 0);
      bus.bright = 8'($urandom);
      cyc();
      n_total++;
      if (bus.out !== m_out || bus.color_idx !== m_idx)
        $display("FAIL auto_model c%0d: out=%h idx=%0d, expected out=%h idx=%0d", c, bus.out, bus.color_idx, m_out, m_idx);
      else n_pass++;
      if (bus.color_idx !== prev) begin
        n_total++;
        if (bus.color_idx !== prev + 3'd1)
          $display("FAIL auto_increment: idx=%0d after %0d, expected %0d", bus.color_idx, prev, prev + 3'd1);
        else n_pass++;
        if (changes > 0) begin
          n_total++;
          if (c - last_chg !== 512)
            $display("FAIL auto_dwell: %0d cycles, expected 512", c - last_chg);
          else n_pass++;
        end
        if (prev == 3'd7 && bus.color_idx == 3'd0) seen_wrap = 1'b1;
        changes++;
        last_chg = c;
        prev = bus.color_idx;
      end
    end
    bus.step = 1'b0;
    n_total++;
    if (changes < 8 || !seen_wrap)
      $display("FAIL auto_progress: %0d changes wrap=%0d, expected >=8 changes wrap=1", changes, seen_wrap);
    else n_pass++;
  endtask

  task automatic test_brightness();
    int unsigned cnt [6];
    bus.auto_en = 1'b0; bus.sw = 6'h3F; bus.bright = 8'd0;
    cyc();
    for (int k = 0; k < 8 && m_idx != 3'd7; k++) begin
      bus.step = 1'b1; cyc(); bus.step = 1'b0; cyc();
    end
    n_total++;
    if (bus.color_idx !== 3'd7)
      $display("FAIL bright_setup_idx: idx=%0d, expected 7", bus.color_idx);
    else n_pass++;
    for (int c = 0; c < 256; c++) begin
      cyc();
      n_total++;
      if (bus.out !== 6'h00)
        $display("FAIL bright0 c%0d: out=%h, expected 00", c, bus.out);
      else n_pass++;
    end
    bus.bright = 8'd64;
    cyc();
    for (int i = 0; i < 6; i++) cnt[i] = 0;
    for (int c = 0; c < 256; c++) begin
      cyc();
      for (int i = 0; i < 6; i++) cnt[i] += 32'(bus.out[i]);
    end
    for (int i = 0; i < 6; i++) begin
      n_total++;
      if (cnt[i] !== ((COMP && i >= 3) ? 32'd0 : 32'd64))
        $display("FAIL bright64 bit%0d: high %0d cycles, expected %0d", i, cnt[i], (COMP && i >= 3) ? 0 : 64);
      else n_pass++;
    end
    bus.sw = 6'h01;
    cyc();
    cnt[0] = 0;
    for (int c = 0; c < 256; c++) begin
      cyc();
      cnt[0] += 32'(bus.out[0]);
      n_total++;
      if (bus.out[5:1] !== 5'd0)
        $display("FAIL sw01_mask c%0d: out=%h, expected bits 5:1 zero", c, bus.out);
      else n_pass++;
    end
    n_total++;
    if (cnt[0] !== 32'd64)
      $display("FAIL sw01_duty: high %0d cycles, expected 64", cnt[0]);
    else n_pass++;
    for (int c = 0; c < 600; c++) begin
      bus.sw = 6'($urandom); bus.bright = 8'($urandom);
      cyc();
      n_total++;
      if (bus.out !== m_out)
        $display("FAIL bright_random c%0d: out=%h, expected %h", c, bus.out, m_out);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    bus.auto_en = 1'b1; bus.sw = 6'h3F; bus.bright = 8'd255;
    repeat (300 + $urandom_range(0, 200)) cyc();
    rst = 1'b1;
    cyc();
    n_total++;
    if (bus.out !== 6'h00 || bus.color_idx !== 3'd0)
      $display("FAIL reset_mid: out=%h idx=%0d, expected out=00 idx=0", bus.out, bus.color_idx);
    else n_pass++;
    rst = 1'b0;
    cyc();
    n_total++;
    if (bus.out !== 6'h00)
      $display("FAIL reset_off_state: out=%h, expected 00", bus.out);
    else n_pass++;
    for (int unsigned n = 2; n <= 600; n++) begin
      cyc();
      n_total++;
      if (bus.color_idx !== ((n >= 512) ? 3'd1 : 3'd0) || bus.out !== m_out)
        $display("FAIL reset_first_wrap n%0d: idx=%0d out=%h, expected idx=%0d out=%h",
                 n, bus.color_idx, bus.out, (n >= 512) ? 1 : 0, m_out);
      else n_pass++;
    end
  endtask

  task automatic test_simultaneous();
    logic [2:0] held;
    bit         found = 1'b0;
    bus.auto_en = 1'b0;
    cyc();
    for (int k = 0; k < 8 && m_idx != 3'd5; k++) begin
      bus.step = 1'b1; cyc(); bus.step = 1'b0; cyc();
    end
    bus.step = 1'b1; bus.auto_en = 1'b1;
    cyc();
    bus.step = 1'b0;
    for (int c = 0; c < 100; c++) begin
      cyc();
      n_total++;
      if (bus.color_idx !== 3'd5)
        $display("FAIL step_vs_auto c%0d: idx=%0d, expected 5", c, bus.color_idx);
      else n_pass++;
    end
    for (int c = 0; c < 2000 && !found; c++) begin
      if ((m_t % 256) == 255 && ((m_wraps + 1) % HOLD) == 0) found = 1'b1;
      else cyc();
    end
    n_total++;
    if (!found) $display("FAIL exit_wrap_search: advancing wrap not reached, expected within 2000 cycles");
    else n_pass++;
    held = bus.color_idx;
    bus.auto_en = 1'b0;
    repeat (3) cyc();
    n_total++;
    if (bus.color_idx !== held)
      $display("FAIL exit_vs_wrap: idx=%0d, expected %0d", bus.color_idx, held);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [2:0] start;
    bus.auto_en = 1'b0; bus.sw = 6'h3F; bus.bright = 8'($urandom);
    start = bus.color_idx;
    bus.step = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      cyc();
      n_total++;
      if (bus.color_idx !== start + 3'(c) || bus.out !== m_out)
        $display("FAIL held_step c%0d: idx=%0d out=%h, expected idx=%0d out=%h",
                 c, bus.color_idx, bus.out, start + 3'(c), m_out);
      else n_pass++;
    end
    bus.step = 1'b0;
  endtask

  initial begin
    bus.sw = 6'h00; bus.auto_en = 1'b0; bus.step = 1'b0; bus.bright = 8'h00;
    @(negedge clk);
    test_reset();
    test_manual_step();
    test_auto();
    test_brightness();
    test_reset_mid();
    test_simultaneous();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
